uart_imem_loader: RTL and testbench
===================================

// Module: uart_imem_loader
// PURPOSE
//  Serial front end of instruction memory: receives 8N1 UART bytes on rx, packs
//  four bytes into one 32-bit instruction and issues a single-cycle write to the
//  IMEM word array at sequential addresses. Runs on the 50 MHz clock.
//  Sits directly upstream of instruction fetch; its writes fill the 64-word
//  program store read at PC[7:2].
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200 baud); min 4
//  ADDR_W        6    IMEM word-address width
//  DEPTH         64   words loaded before done; must be <= 2**ADDR_W
// PORTS
//  clk        in   1       system clock (50 MHz domain)
//  reset      in   1       asynchronous, active-high reset
//  clear      in   1       synchronous restart of a load (addr, byte count, flags to 0)
//  rx         in   1       UART serial input, idle high, asynchronous to clk
//  wr_en      out  1       one-cycle IMEM write strobe
//  wr_addr    out  ADDR_W  IMEM word address, valid while wr_en=1
//  wr_data    out  32      instruction word, valid while wr_en=1
//  byte_valid out  1       one-cycle pulse per accepted byte
//  byte_data  out  8       last accepted byte
//  busy       out  1       1 while rx FSM is not in IDLE
//  done       out  1       sticky: DEPTH words written
//  frame_err  out  1       sticky: bad stop bit (or parity) seen since reset/clear
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; addr=0; byte_cnt=0; word reg=0.
//  - rx passes a 2-flop synchronizer before use (2-cycle input latency).
//  - RX FSM: IDLE -> START on synchronized rx=0. START: wait CLKS_PER_BIT/2;
//    rx=1 -> false start, back to IDLE; rx=0 -> DATA. DATA: sample 8 bits LSB
//    first, each CLKS_PER_BIT after the previous sample (mid-bit). -> STOP.
//    STOP: sample after CLKS_PER_BIT; rx=1 -> byte accepted, byte_valid pulses
//    the next cycle; rx=0 -> frame_err set, byte discarded. Then IDLE.
//  - Baud counter reloads on every state entry; no free-running divider.
//  - Packing big-endian: word <= {word[23:0], byte}; first byte = bits [31:24].
//  - On 4th accepted byte: wr_en=1 for exactly one cycle, wr_addr=addr,
//    wr_data=packed word; addr increments the cycle after; byte_cnt -> 0.
//  - When word DEPTH-1 is written: done=1 the cycle after wr_en; addr stays at
//    DEPTH-1 (no wrap); further bytes still raise byte_valid but never wr_en.
//  - frame_err does not block loading; a discarded byte does not advance byte_cnt.
//  - clear: addr, byte_cnt, word, done, frame_err -> 0 next edge; RX FSM keeps
//    running. clear in same cycle as a 4th-byte completion: clear wins, no wr_en.
//  - reset mid-frame: FSM to IDLE immediately; partial word lost.
//  - busy=0 only in IDLE; wr_en never asserted while reset=1.
// CONFIGURATION
//  LOADER_PARITY_EN defined: 8E1 frame; PARITY state between DATA and STOP
//   samples an even-parity bit; mismatch sets frame_err and discards the byte
//   (STOP still traversed). Undefined: 8N1, no PARITY state, no parity logic.
// TESTING (CLKS_PER_BIT=8, DEPTH=4 unless noted)
//  1 Bytes 12 34 56 78 -> one wr_en, wr_addr=0, wr_data=32'h12345678; byte_valid x4.
//  2 16 bytes -> wr_en at addr 0..3, done=1 after 4th write; 17th byte -> no wr_en.
//  3 rx low 2 cycles then high (glitch) -> no byte_valid, busy returns 0, no error.
//  4 Frame with stop bit=0 -> frame_err=1, byte dropped; next 4 good bytes give
//    exactly one word at addr 0.
//  5 3 bytes sent, clear pulsed, 4 bytes AA BB CC DD -> wr_data=32'hAABBCCDD, addr 0.
//  6 reset asserted mid DATA -> all outputs 0 same cycle; next full word at addr 0.
//    With LOADER_PARITY_EN: byte 8'h01 with parity bit 0 -> frame_err=1, dropped.

Source files
------------

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader
// Purpose  : UART receiver (8N1, or 8E1 when LOADER_PARITY_EN is defined) that
//            packs four bytes big-endian into sequential 32-bit IMEM writes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 6,
    parameter int DEPTH        = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0]  c_LAST  = ADDR_W'(DEPTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef LOADER_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic               r_rx_meta;
    logic               r_rx_sync;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_baud;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_sample;
    logic               w_accept;
    logic               w_frame_bad;
`ifdef LOADER_PARITY_EN
    logic               r_par_err;
`endif

    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_word;
    logic [1:0]         r_byte_cnt;
    logic               r_byte_valid;
    logic [7:0]         r_byte_data;
    logic               r_done;
    logic               r_frame_err;

    // Synchronizer resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_sample = (r_baud == '0);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!r_rx_sync) w_state_next = c_START;
            end
            c_START: begin
                if (w_sample) w_state_next = r_rx_sync ? c_IDLE : c_DATA;
            end
            c_DATA: begin
                if (w_sample && (r_bit_idx == 3'd7)) begin
`ifdef LOADER_PARITY_EN
                    w_state_next = c_PARITY;
`else
                    w_state_next = c_STOP;
`endif
                end
            end
`ifdef LOADER_PARITY_EN
            c_PARITY: begin
                if (w_sample) begin
                    w_state_next = c_STOP;
                    w_frame_bad  = (r_rx_sync != ^r_shift);
                end
            end
`endif
            c_STOP: begin
                if (w_sample) begin
                    w_state_next = c_IDLE;
                    if (!r_rx_sync) begin
                        w_frame_bad = 1'b1;
`ifdef LOADER_PARITY_EN
                    end else if (!r_par_err) begin
`else
                    end else begin
`endif
                        w_accept = 1'b1;
                    end
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Baud counter reloads on each state entry and after every mid-bit sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_state_next != r_state) begin
                r_baud <= (w_state_next == c_START) ? c_HALF : c_FULL;
            end else if (r_state != c_IDLE) begin
                r_baud <= w_sample ? c_FULL : (r_baud - c_ONE);
            end
            if (r_state == c_START) begin
                r_bit_idx <= '0;
            end
            if ((r_state == c_DATA) && w_sample) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

`ifdef LOADER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else if ((r_state == c_PARITY) && w_sample) begin
            r_par_err <= w_frame_bad;
        end else if (r_state == c_IDLE) begin
            r_par_err <= 1'b0;
        end
    end
`endif

    // Word packer; clear takes priority over a completing 4th byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_accept;
            r_wr_en      <= 1'b0;
            if (w_accept) begin
                r_byte_data <= r_shift;
            end
            if (clear) begin
                r_addr      <= '0;
                r_word      <= '0;
                r_byte_cnt  <= '0;
                r_done      <= 1'b0;
                r_frame_err <= 1'b0;
            end else begin
                if (w_frame_bad) begin
                    r_frame_err <= 1'b1;
                end
                if (r_wr_en) begin
                    if (r_addr == c_LAST) begin
                        r_done <= 1'b1;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                if (w_accept) begin
                    r_word <= {r_word[23:0], r_shift};
                    if (r_byte_cnt == 2'd3) begin
                        r_byte_cnt <= '0;
                        r_wr_en    <= !r_done;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_addr;
    assign wr_data    = r_word;
    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_imem_loader
// Purpose  : Self-checking bench; UART frames driven bit by bit, writes
//            compared against a byte-queue packing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_imem_loader;

    localparam int CLKS_PER_BIT = 8;
    localparam int ADDR_W       = 6;
    localparam int DEPTH        = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              rx    = 1'b1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic              par_flip = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] got_addr[$];
    logic [7:0]        got_bytes[$];

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            got_data.push_back(wr_data);
            got_addr.push_back(wr_addr);
        end
        if (byte_valid) got_bytes.push_back(byte_data);
    end

    // Reference: n-th written word is bytes 4n..4n+3 of the accepted stream, MSB first
    function automatic logic [31:0] model_word(input logic [7:0] q[$], input int n);
        return {q[4*n], q[4*n+1], q[4*n+2], q[4*n+3]};
    endfunction

    function automatic int model_nwords(input int nbytes);
        return (nbytes / 4 > DEPTH) ? DEPTH : nbytes / 4;
    endfunction

    task automatic mon_reset;
        got_data.delete();
        got_addr.delete();
        got_bytes.delete();
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef LOADER_PARITY_EN
        bit_time((^b) ^ par_flip);
`endif
        bit_time(stop_bit);
        bit_time(1'b1);
        bit_time(1'b1);
    endtask

    task automatic send_random(input int n, inout logic [7:0] q[$]);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(255));
            q.push_back(b);
            send_frame(b, 1'b1);
        end
    endtask

    task automatic do_clear;
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({wr_en, wr_addr, wr_data, byte_valid, byte_data, busy, done, frame_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%h data=%h bv=%b bd=%h busy=%b done=%b ferr=%b, expected all 0",
                     wr_en, wr_addr, wr_data, byte_valid, byte_data, busy, done, frame_err);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word;
        logic [7:0] sent[$];
        sent = '{8'h12, 8'h34, 8'h56, 8'h78};
        mon_reset();
        foreach (sent[i]) send_frame(sent[i], 1'b1);
        tests_run++;
        if (got_data.size() != 1 || got_addr[0] !== '0 || got_data[0] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL single_word: got %0d writes first addr=%h data=%h, expected 1 write addr=0 data=12345678",
                     got_data.size(), (got_addr.size() > 0) ? got_addr[0] : '1, (got_data.size() > 0) ? got_data[0] : 32'hx);
        end
        tests_run++;
        if (got_bytes.size() != 4) begin
            tests_failed++;
            $display("FAIL single_bytes_count: got %0d byte_valid, expected 4", got_bytes.size());
        end
        for (int i = 0; i < 4 && i < got_bytes.size(); i++) begin
            tests_run++;
            if (got_bytes[i] !== sent[i]) begin
                tests_failed++;
                $display("FAIL single_byte_data[%0d]: got %h expected %h", i, got_bytes[i], sent[i]);
            end
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_flags: got busy=%b done=%b ferr=%b, expected 0 0 0", busy, done, frame_err);
        end
    endtask

    task automatic test_fill;
        logic [7:0] sent[$];
        int nw;
        do_clear();
        mon_reset();
        send_random(4 * DEPTH + 1, sent);
        nw = model_nwords(sent.size());
        tests_run++;
        if (got_data.size() != nw) begin
            tests_failed++;
            $display("FAIL fill_write_count: got %0d expected %0d", got_data.size(), nw);
        end
        for (int i = 0; i < nw && i < got_data.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== model_word(sent, i)) begin
                tests_failed++;
                $display("FAIL fill_word[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         i, got_addr[i], got_data[i], ADDR_W'(i), model_word(sent, i));
            end
        end
        tests_run++;
        if (done !== 1'b1 || wr_addr !== ADDR_W'(DEPTH - 1)) begin
            tests_failed++;
            $display("FAIL fill_done: got done=%b addr=%h expected done=1 addr=%h", done, wr_addr, ADDR_W'(DEPTH - 1));
        end
        tests_run++;
        if (got_bytes.size() != sent.size() || byte_data !== sent[sent.size() - 1]) begin
            tests_failed++;
            $display("FAIL fill_bytes: got %0d bytes last=%h expected %0d last=%h",
                     got_bytes.size(), byte_data, sent.size(), sent[sent.size() - 1]);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] sent[$];
        mon_reset();
        bit_time(1'b0);
        bit_time(1'b1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_busy: got %b expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({wr_en, wr_addr, wr_data, byte_valid, byte_data, busy, done, frame_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got addr=%h data=%h bd=%h busy=%b done=%b, expected all 0",
                     wr_addr, wr_data, byte_data, busy, done);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 * CLKS_PER_BIT) @(negedge clk);
        mon_reset();
        send_random(4, sent);
        tests_run++;
        if (got_data.size() != 1 || got_addr[0] !== '0 || got_data[0] !== model_word(sent, 0)) begin
            tests_failed++;
            $display("FAIL reset_mid_word: got %0d writes, expected 1 at addr 0 data=%h", got_data.size(), model_word(sent, 0));
        end
    endtask

    task automatic test_glitch;
        do_clear();
        mon_reset();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLKS_PER_BIT) @(negedge clk);
        tests_run++;
        if (got_bytes.size() != 0 || busy !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch: got bytes=%0d busy=%b ferr=%b expected 0 0 0", got_bytes.size(), busy, frame_err);
        end
    endtask

    task automatic test_frame_err;
        logic [7:0] sent[$];
        do_clear();
        mon_reset();
        send_frame(8'($urandom_range(255)), 1'b0);
        tests_run++;
        if (frame_err !== 1'b1 || got_bytes.size() != 0) begin
            tests_failed++;
            $display("FAIL frame_err_set: got ferr=%b bytes=%0d expected 1 0", frame_err, got_bytes.size());
        end
        send_random(4, sent);
        tests_run++;
        if (got_data.size() != 1 || got_addr[0] !== '0 || got_data[0] !== model_word(sent, 0)) begin
            tests_failed++;
            $display("FAIL frame_err_recover: got %0d writes, expected 1 at addr 0 data=%h", got_data.size(), model_word(sent, 0));
        end
        tests_run++;
        if (frame_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_err_sticky: got %b expected 1", frame_err);
        end
    endtask

    task automatic test_clear;
        logic [7:0] junk[$];
        logic [7:0] sent[$];
        do_clear();
        tests_run++;
        if (frame_err !== 1'b0 || done !== 1'b0 || wr_addr !== '0) begin
            tests_failed++;
            $display("FAIL clear_flags: got ferr=%b done=%b addr=%h expected 0 0 0", frame_err, done, wr_addr);
        end
        mon_reset();
        send_random(3, junk);
        do_clear();
        sent = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        foreach (sent[i]) send_frame(sent[i], 1'b1);
        tests_run++;
        if (got_data.size() != 1 || got_addr[0] !== '0 || got_data[0] !== 32'hAABBCCDD) begin
            tests_failed++;
            $display("FAIL clear_restart: got %0d writes, expected 1 at addr 0 data=aabbccdd", got_data.size());
        end
    endtask

    task automatic test_clear_collision;
        logic [7:0] pre[$];
        logic [7:0] sent[$];
        do_clear();
        mon_reset();
        send_random(3, pre);
        fork
            send_frame(8'($urandom_range(255)), 1'b1);
            begin
                repeat (76) @(negedge clk);
                clear = 1'b1;
                repeat (6) @(negedge clk);
                clear = 1'b0;
            end
        join
        tests_run++;
        if (got_data.size() != 0 || got_bytes.size() != 4) begin
            tests_failed++;
            $display("FAIL clear_collision: got writes=%0d bytes=%0d expected 0 4", got_data.size(), got_bytes.size());
        end
        send_random(4, sent);
        tests_run++;
        if (got_data.size() != 1 || got_addr[0] !== '0 || got_data[0] !== model_word(sent, 0)) begin
            tests_failed++;
            $display("FAIL clear_collision_next: got %0d writes, expected 1 at addr 0 data=%h", got_data.size(), model_word(sent, 0));
        end
    endtask

`ifdef LOADER_PARITY_EN
    task automatic test_parity;
        do_clear();
        mon_reset();
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        par_flip = 1'b0;
        tests_run++;
        if (frame_err !== 1'b1 || got_bytes.size() != 0) begin
            tests_failed++;
            $display("FAIL parity_err: got ferr=%b bytes=%0d expected 1 0", frame_err, got_bytes.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_reset_mid();
        test_glitch();
        test_frame_err();
        test_clear();
        test_clear_collision();
`ifdef LOADER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
